// File: rtl/fp_add_arb_pkg.sv
// Shared types for the FP adder arbiter: FSM states, requester tag and one-hot helper.
package fp_add_arb_pkg;

    localparam int unsigned FP_W    = 32;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned ID_W    = $clog2(MAX_REQ);

    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [MAX_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps modulo NUM_REQ.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     winner
);

    always_comb begin
        logic        found;
        int unsigned idx;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!found && req[IDW'(idx)]) begin
                found              = 1'b1;
                grant[IDW'(idx)]   = 1'b1;
                winner             = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one pipelined FP adder between NUM_REQ requesters.
// Define FP_ADD_ARB_SUB_EN to add a per-requester req_sub input (ax - ay).
module fp_add_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADD_LATENCY = 3,
    parameter int unsigned FP_W        = fp_add_arb_pkg::FP_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*FP_W-1:0] req_ax,
    input  logic [NUM_REQ*FP_W-1:0] req_ay,
`ifdef FP_ADD_ARB_SUB_EN
    input  logic [NUM_REQ-1:0]      req_sub,
`endif
    output logic [FP_W-1:0]         add_ax,
    output logic [FP_W-1:0]         add_ay,
    output logic                    add_ena,
    output logic                    add_clr,
    input  logic [FP_W-1:0]         add_result,
    output logic [NUM_REQ-1:0]      res_valid,
    output logic [FP_W-1:0]         res_data,
    output logic                    busy
);
    import fp_add_arb_pkg::*;

    localparam int unsigned IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W  = (ADD_LATENCY > 0) ? $clog2(ADD_LATENCY + 1) : 1;
    localparam int unsigned STAGES = ADD_LATENCY + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADD_LATENCY);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     winner;
    logic [NUM_REQ-1:0] grant;
    logic               xfer;
    logic               ena_q;
    logic [FP_W-1:0]    ax_q, ay_q;
    logic [FP_W-1:0]    sel_ax, sel_ay, raw_ay;
    tag_t               tag_in;
    tag_t               tag_q [STAGES];

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .req    (req_valid),
        .ptr    (ptr_q),
        .grant  (grant),
        .winner (winner)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        add_clr   = 1'b1;
        req_ready = '0;
        unique case (state_q)
            // Hold the adder in clear until every pipeline stage has been flushed.
            StInit: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                add_clr   = 1'b0;
                req_ready = grant;
            end
        endcase
    end

    assign xfer   = |(req_valid & req_ready);
    assign sel_ax = req_ax[winner*FP_W +: FP_W];
    assign raw_ay = req_ay[winner*FP_W +: FP_W];

`ifdef FP_ADD_ARB_SUB_EN
    // Subtraction is a sign flip of ay; NaNs are flipped like any other value.
    assign sel_ay = req_sub[winner] ? {~raw_ay[FP_W-1], raw_ay[FP_W-2:0]} : raw_ay;
`else
    assign sel_ay = raw_ay;
`endif

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    assign tag_in.valid = xfer;
    assign tag_in.id    = ID_W'(winner);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            cnt_q   <= '0;
            ptr_q   <= '0;
            ena_q   <= 1'b0;
            ax_q    <= '0;
            ay_q    <= '0;
            for (int i = 0; i < STAGES; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ena_q   <= 1'b1;
            if (xfer) begin
                ax_q <= sel_ax;
                ay_q <= sel_ay;
            end
            tag_q[0] <= tag_in;
            for (int i = 1; i < STAGES; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            busy = busy | tag_q[i].valid;
        end
    end

    assign add_ax    = ax_q;
    assign add_ay    = ay_q;
    assign add_ena   = ena_q;
    assign res_data  = add_result;
    assign res_valid = tag_q[STAGES-1].valid ? NUM_REQ'(onehot(tag_q[STAGES-1].id)) : '0;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Randomised bench for fp_add_arbiter with a behavioural adder and result scoreboard.
module tb_fp_add_arbiter;

    localparam int NR  = 4;
    localparam int LAT = 3;
    localparam int W   = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid, req_ready, res_valid;
    logic [NR*W-1:0]   req_ax, req_ay;
`ifdef FP_ADD_ARB_SUB_EN
    logic [NR-1:0]     req_sub;
`endif
    logic [W-1:0]      add_ax, add_ay, add_result, res_data;
    logic              add_ena, add_clr, busy;

    always #5 clk = ~clk;

    fp_add_arbiter #(
        .NUM_REQ(NR),
        .ADD_LATENCY(LAT),
        .FP_W(W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ax     (req_ax),
        .req_ay     (req_ay),
`ifdef FP_ADD_ARB_SUB_EN
        .req_sub    (req_sub),
`endif
        .add_ax     (add_ax),
        .add_ay     (add_ay),
        .add_ena    (add_ena),
        .add_clr    (add_clr),
        .add_result (add_result),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .busy       (busy)
    );

    // Integer-valued single-precision helpers (operands kept below 2^24 so sums are exact).
    function automatic int fp_to_int(input logic [31:0] f);
        int e;
        int m;
        int v;
        if (f[30:23] == 8'd0) return 0;
        e = int'(f[30:23]) - 127;
        m = int'({1'b1, f[22:0]});
        if (e < 0) v = 0;
        else if (e <= 23) v = m >>> (23 - e);
        else v = m <<< (e - 23);
        return f[31] ? -v : v;
    endfunction

    function automatic logic [31:0] int_to_fp(input int v);
        logic [31:0] m;
        int          p;
        logic        s;
        if (v == 0) return 32'h0;
        s = (v < 0);
        m = s ? 32'(-v) : 32'(v);
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        m = m << (23 - p);
        return {s, 8'(127 + p), m[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        int v;
        v = int'($urandom_range(4000));
        if ($urandom_range(1) == 1) v = -v;
        return int_to_fp(v);
    endfunction

    // Behavioural sp_add: LAT-deep pipeline with sync clear and clock enable.
    logic [W-1:0] apipe [LAT];
    always @(posedge clk) begin
        if (add_clr) begin
            for (int i = 0; i < LAT; i++) apipe[i] <= '0;
        end else if (add_ena) begin
            apipe[0] <= int_to_fp(fp_to_int(add_ax) + fp_to_int(add_ay));
            for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
        end
    end
    assign add_result = apipe[LAT-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    int          cyc = 0;
    int          init_left = 0;
    int          ptr = 0;
    logic [31:0] exp_ax = '0;
    logic [31:0] exp_ay = '0;
    logic [NR-1:0] last_rv;
    logic [31:0]   last_rd;

    task automatic sample_and_check();
        logic [NR-1:0] exp_ready;
        logic [NR-1:0] exp_rv;
        int            win;
        int            idx;
        logic [31:0]   a, b;
        logic          sub;
        exp_t          it;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            check_eq("rst_ready", req_ready, '0);
            check_eq("rst_add_ax", add_ax, '0);
            check_eq("rst_add_ay", add_ay, '0);
            check_eq("rst_ena", add_ena, 1'b0);
            check_eq("rst_clr", add_clr, 1'b1);
            check_eq("rst_res_valid", res_valid, '0);
            check_eq("rst_busy", busy, 1'b0);
            return;
        end
        exp_ready = '0;
        win       = -1;
        if (init_left > 0) begin
            check_eq("init_clr", add_clr, 1'b1);
            init_left--;
        end else begin
            check_eq("run_clr", add_clr, 1'b0);
            check_eq("run_ena", add_ena, 1'b1);
            for (int k = 0; k < NR; k++) begin
                idx = (ptr + k) % NR;
                if (win < 0 && req_valid[idx]) win = idx;
            end
            if (win >= 0) exp_ready[win] = 1'b1;
        end
        check_eq("req_ready", req_ready, exp_ready);
        check_eq("add_ax", add_ax, exp_ax);
        check_eq("add_ay", add_ay, exp_ay);
        check_eq("busy", busy, sb.size() != 0);
        exp_rv = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            it = sb.pop_front();
            exp_rv[it.id] = 1'b1;
            check_eq("res_data", res_data, it.data);
        end
        check_eq("res_valid", res_valid, exp_rv);
        if (res_valid != '0) begin
            last_rv = res_valid;
            last_rd = res_data;
        end
        if (win >= 0) begin
            a = req_ax[win*W +: W];
            b = req_ay[win*W +: W];
`ifdef FP_ADD_ARB_SUB_EN
            sub = req_sub[win];
`else
            sub = 1'b0;
`endif
            exp_ax = a;
            exp_ay = sub ? {~b[31], b[30:0]} : b;
            it.due  = cyc + 1 + LAT;
            it.id   = win;
            it.data = int_to_fp(sub ? fp_to_int(a) - fp_to_int(b) : fp_to_int(a) + fp_to_int(b));
            sb.push_back(it);
            grant_log.push_back(win);
            ptr = (win + 1) % NR;
        end
    endtask

    task automatic step();
        sample_and_check();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin
            req_ax[i*W +: W] = rnd_fp();
            req_ay[i*W +: W] = rnd_fp();
        end
`ifdef FP_ADD_ARB_SUB_EN
        req_sub = NR'($urandom);
`endif
    endtask

    task automatic do_reset(input int n);
        rst_n     = 1'b0;
        sb.delete();
        ptr       = 0;
        exp_ax    = '0;
        exp_ay    = '0;
        init_left = LAT + 1;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    task automatic single(input int id);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        rand_ops();
        step();
        req_valid = '0;
    endtask

    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_sparse[3] = '{1, 2, 1};

    initial begin
        req_valid = '0;
        req_ax    = '0;
        req_ay    = '0;
`ifdef FP_ADD_ARB_SUB_EN
        req_sub   = '0;
`endif
        last_rv   = '0;
        last_rd   = '0;

        // Reset, then flush window with requests pending (none may be granted).
        do_reset(3);
        for (int i = 0; i < LAT + 1; i++) begin
            req_valid = NR'($urandom) | NR'(1);
            rand_ops();
            step();
        end
        req_valid = '0;
        repeat (3) step();

        // Single request: 1.0 + 2.0.
        last_rv = '0;
        req_valid = 4'b0001;
        req_ax[0 +: W] = 32'h3F800000;
        req_ay[0 +: W] = 32'h40000000;
        step();
        req_valid = '0;
        repeat (LAT + 1) step();
        check_eq("single_rv", last_rv, 4'b0001);
        check_eq("single_data", last_rd, 32'h40400000);

        // Full contention starting from ptr=0.
        single(3);
        repeat (LAT + 1) step();
        grant_log.delete();
        req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            step();
        end
        req_valid = '0;
        repeat (LAT + 1) step();
        check_eq("full_count", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            check_eq($sformatf("full_order%0d", i), grant_log[i], exp_order[i]);
        end

        // Sparse with wrap: ptr=3, only req1 and req2 valid.
        single(2);
        repeat (LAT + 1) step();
        grant_log.delete();
        req_valid = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            step();
        end
        req_valid = '0;
        repeat (LAT + 1) step();
        check_eq("sparse_count", grant_log.size(), 3);
        for (int i = 0; i < 3 && i < grant_log.size(); i++) begin
            check_eq($sformatf("sparse_order%0d", i), grant_log[i], exp_sparse[i]);
        end

`ifdef FP_ADD_ARB_SUB_EN
        // Subtraction: 3.0 - 1.0 on requester 2.
        last_rv = '0;
        req_valid = 4'b0100;
        req_ax[2*W +: W] = 32'h40400000;
        req_ay[2*W +: W] = 32'h3F800000;
        req_sub = 4'b0100;
        step();
        req_valid = '0;
        req_sub   = '0;
        check_eq("sub_add_ay", add_ay, 32'hBF800000);
        repeat (LAT + 1) step();
        check_eq("sub_rv", last_rv, 4'b0100);
        check_eq("sub_data", last_rd, 32'h40000000);
`endif

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            req_valid = NR'($urandom);
            rand_ops();
            step();
        end
        req_valid = '0;
        repeat (LAT + 1) step();

        // Reset with three operations in flight.
        req_valid = '1;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            step();
        end
        req_valid = '0;
        step();
        check_eq("midflight_busy", busy, 1'b1);
        do_reset(2);
        check_eq("post_rst_busy", busy, 1'b0);
        for (int i = 0; i < LAT + 6; i++) begin
            req_valid = NR'($urandom);
            rand_ops();
            step();
        end
        req_valid = '0;
        repeat (LAT + 2) step();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
